sequence_player: RTL and testbench

Reads the stored colour pattern back out of the Simon pattern memory and plays it on the four colour LEDs, one entry at a time. It is the read-side counterpart of the level loader, which writes random colours into that memory. The control FSM pulses `start` with the current level. The player walks addresses 0..`last_idx`, lights each colour for a fixed on-time, blanks for a fixed gap, and reports completion with `done`.

---
 rtl/simon_pkg.sv | 11 +
 rtl/sequence_player_phase_timer.sv | 18 +
 rtl/sequence_player.sv | 72 +++++++
 tb/tb_sequence_player.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: colour codes, one-hot LED decode and player state encodings
package simon_pkg;
  localparam logic [1:0] BLUE   = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [1:0] YELLOW = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ON, S_OFF, S_DONE} state_t;
  function automatic logic [3:0] colour_onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction
endpackage

// File: rtl/sequence_player_phase_timer.sv
// phase_timer: loadable down-counter; clk/resetn, load/load_val in, tc high at zero
module phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!resetn) r_cnt <= '0;
    else if (load) r_cnt <= load_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign tc = (r_cnt == '0);
endmodule

// File: rtl/sequence_player.sv
// sequence_player: plays pattern memory entries 0..last_idx on one-hot LEDs; start/last_idx in, rd_addr/rd_data memory port, led/busy/done out
module sequence_player
  import simon_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int ON_CYCLES  = 50_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int CNT_W      = $clog2((ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES) + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_idx, r_last;
  logic [1:0]        r_colour;
  logic              w_tc, w_load;
  logic [CNT_W-1:0]  w_load_val;
  logic              w_last;
  assign w_last = (r_idx == r_last);
  // FETCH arms the on-time; the ON terminal count re-arms the same counter for the gap
  assign w_load     = (r_state == S_FETCH) || (r_state == S_ON && w_tc);
  assign w_load_val = (r_state == S_FETCH) ? CNT_W'(ON_CYCLES - 1) : CNT_W'(OFF_CYCLES - 1);
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (w_load),
    .load_val (w_load_val),
    .tc       (w_tc)
  );
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_FETCH : S_IDLE;
      S_FETCH: w_next = S_ON;
      S_ON:    w_next = w_tc ? S_OFF : S_ON;
      S_OFF:   w_next = w_tc ? (w_last ? S_DONE : S_FETCH) : S_OFF;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_idx    <= '0;
      r_last   <= '0;
      r_colour <= BLUE;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_idx  <= '0;
        r_last <= last_idx;
      end
      if (r_state == S_FETCH) r_colour <= rd_data;
      if (r_state == S_OFF && w_tc && !w_last) r_idx <= r_idx + 1'b1;
    end
  end
  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
    led     = (r_state == S_ON) ? colour_onehot(r_colour) : 4'b0000;
    rd_addr = (r_state == S_FETCH || r_state == S_ON || r_state == S_OFF) ? r_idx : '0;
  end
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: directed checks of playback timing, LED decode, abort and restart behaviour
module tb_sequence_player;
  import simon_pkg::*;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [2:0] last_idx = 3'd0;
  logic [2:0] rd_addr;
  logic [1:0] rd_data;
  logic [3:0] led;
  logic       busy, done;
  logic [1:0] mem [8];
  logic [3:0] pat [8];
  int vecs = 0;
  int errs = 0;
  int nb, nd, nl, e, p;
  logic [3:0] exp_led;
  logic [2:0] exp_addr;
  assign rd_data = mem[rd_addr];
  always #5 clk = ~clk;
  sequence_player #(.ADDR_W(3), .ON_CYCLES(3), .OFF_CYCLES(2)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .last_idx (last_idx),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    mem = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    step();
    step();
    chk("rst_led", led, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", rd_addr, 3'd0);
    resetn = 1'b1;
    step();
    chk("idle_busy", busy, 1'b0);
    // single entry, green
    last_idx = 3'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t1_led_%0d", k), led, (k >= 2 && k <= 4) ? 4'b0010 : 4'b0000);
      chk($sformatf("t1_busy_%0d", k), busy, (k >= 1 && k <= 7));
      chk($sformatf("t1_done_%0d", k), done, k == 7);
      chk($sformatf("t1_addr_%0d", k), rd_addr, 3'd0);
      step();
    end
    // all eight entries
    mem = '{BLUE, GREEN, RED, YELLOW, YELLOW, RED, GREEN, BLUE};
    pat = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    last_idx = 3'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      e = (k - 1) / 6;
      p = (k - 1) % 6;
      exp_led  = (k <= 48 && p >= 1 && p <= 3) ? pat[e] : 4'b0000;
      exp_addr = (k <= 48) ? 3'(e) : 3'd0;
      chk($sformatf("t2_led_%0d", k), led, exp_led);
      chk($sformatf("t2_addr_%0d", k), rd_addr, exp_addr);
      chk($sformatf("t2_busy_%0d", k), busy, k <= 49);
      chk($sformatf("t2_done_%0d", k), done, k == 49);
      step();
    end
    // start and last_idx disturbed mid-playback
    last_idx = 3'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    nb = 0; nd = 0; nl = 0;
    for (int k = 1; k <= 20; k++) begin
      nb += int'(busy);
      nd += int'(done);
      nl += int'(led != 4'b0000);
      if (k == 3) begin
        start = 1'b1;
        last_idx = 3'd5;
      end else start = 1'b0;
      step();
    end
    chk("t3_busy_cycles", 8'(nb), 8'd13);
    chk("t3_done_count", 8'(nd), 8'd1);
    chk("t3_lit_cycles", 8'(nl), 8'd6);
    // reset during ON of entry 1
    last_idx = 3'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    chk("t4_pre_led", led, 4'b0010);
    chk("t4_pre_addr", rd_addr, 3'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("t4_rst_led", led, 4'b0000);
    chk("t4_rst_busy", busy, 1'b0);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      nd += int'(done);
      step();
    end
    chk("t4_no_done", 8'(nd), 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_re_addr", rd_addr, 3'd0);
    chk("t4_re_busy", busy, 1'b1);
    step();
    chk("t4_re_led", led, 4'b0001);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    // memory overwritten while lit
    mem[0] = GREEN;
    mem[1] = YELLOW;
    last_idx = 3'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t5_led_2", led, 4'b0010);
    mem[0] = RED;
    step();
    chk("t5_led_3", led, 4'b0010);
    step();
    chk("t5_led_4", led, 4'b0010);
    step();
    step();
    step();
    chk("t5_addr_7", rd_addr, 3'd1);
    step();
    chk("t5_led_8", led, 4'b1000);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    // start held: back-to-back runs with one IDLE cycle between
    last_idx = 3'd0;
    start = 1'b1;
    step();
    for (int k = 1; k <= 24; k++) begin
      chk($sformatf("t6_busy_%0d", k), busy, (k % 8) != 0);
      chk($sformatf("t6_done_%0d", k), done, (k % 8) == 7);
      step();
    end
    start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("t6_end_busy", busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
